// File: rtl/mux_2x1_rr_feeder_seq_pkg.sv
// Shared constants for the 2-to-1 round-robin mux feeder.
//   CMD_LOW / CMD_HIGH     : o_cmd encodings selecting lane 0 / lane 1
//   LANE_LOW / LANE_HIGH   : lane index constants
//   FIFO_DEPTH_DEFAULT     : default entries per lane FIFO
package mux_2x1_rr_feeder_seq_pkg;

  localparam logic CMD_LOW  = 1'b0;
  localparam logic CMD_HIGH = 1'b1;

  localparam logic LANE_LOW  = 1'b0;
  localparam logic LANE_HIGH = 1'b1;

  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/mux_2x1_rr_feeder_seq_if.sv
// Bus bundle between the upstream producers / downstream mux and the feeder.
//   i_valid, i_data_bus, i_stall : driven by the environment (master)
//   o_ready, o_valid, o_data_bus,
//   o_en, o_cmd                  : driven by the feeder (slave)
//
// Handshake: lane k transfers a word on a rising edge where
// i_valid[k] && o_ready[k]. o_ready depends only on registered FIFO
// counts, so a producer may hold i_valid and data until it sees ready.
// Downstream has no ready: the feeder issues at most one word per cycle
// whenever i_stall is low, and the mux must take it.
interface mux_2x1_rr_feeder_seq_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 1
);
  logic [1:0]              i_valid;
  logic [2*DATA_WIDTH-1:0] i_data_bus;
  logic [1:0]              o_ready;
  logic                    i_stall;
  logic [1:0]              o_valid;
  logic [2*DATA_WIDTH-1:0] o_data_bus;
  logic                    o_en;
  logic [COMMAND_WIDTH-1:0] o_cmd;

  modport master (
    output i_valid, i_data_bus, i_stall,
    input  o_ready, o_valid, o_data_bus, o_en, o_cmd
  );

  modport slave (
    input  i_valid, i_data_bus, i_stall,
    output o_ready, o_valid, o_data_bus, o_en, o_cmd
  );
endinterface

// File: rtl/mux_2x1_rr_feeder_seq_sync_fifo.sv
// Single-clock FIFO used as a per-lane buffer.
//   clk, rst_n : clock, synchronous active-low reset (flushes pointers/count)
//   push       : write wr_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rd_data    : current head entry (valid when !empty)
//   empty/full : derived from the registered count
module sync_fifo_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly log2(depth) bits so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mux_2x1_rr_feeder_seq.sv
// Feeder for the 2-to-1 sequential mux: buffers two valid/ready lanes in
// FIFOs, grants one non-empty lane per cycle round-robin, and registers
// the mux controls for the granted word.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : i_valid/i_data_bus/o_ready upstream lanes, i_stall hold,
//                o_en/o_cmd/o_valid/o_data_bus registered mux controls
//   dbg_last_grant : lane that won the most recent issue (observability)
module mux_2x1_rr_feeder_seq
  import mux_2x1_rr_feeder_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 1,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mux_2x1_rr_feeder_seq_if.slave   bus,
  output logic                     dbg_last_grant
);
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            empty;
  logic [1:0]            full;
  logic [DATA_WIDTH-1:0] head_low;
  logic [DATA_WIDTH-1:0] head_high;

  logic                  last_grant;
  logic                  grant_vld;
  logic                  grant_lane;

  // Ready comes straight from the registered counts: no pop credit.
  assign bus.o_ready    = ~full;
  assign push           = bus.i_valid & ~full;
  assign dbg_last_grant = last_grant;

  sync_fifo_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_low (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push[0]),
    .pop     (pop[0]),
    .wr_data (bus.i_data_bus[DATA_WIDTH-1:0]),
    .rd_data (head_low),
    .empty   (empty[0]),
    .full    (full[0])
  );

  sync_fifo_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_high (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push[1]),
    .pop     (pop[1]),
    .wr_data (bus.i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]),
    .rd_data (head_high),
    .empty   (empty[1]),
    .full    (full[1])
  );

  // Round-robin: on a tie the lane that did not win last time goes.
  always_comb begin
    grant_vld  = 1'b0;
    grant_lane = LANE_LOW;
    if (!bus.i_stall) begin
      case (~empty)
        2'b11: begin
          grant_vld  = 1'b1;
          grant_lane = ~last_grant;
        end
        2'b01: begin
          grant_vld  = 1'b1;
          grant_lane = LANE_LOW;
        end
        2'b10: begin
          grant_vld  = 1'b1;
          grant_lane = LANE_HIGH;
        end
        default: begin
          grant_vld  = 1'b0;
          grant_lane = LANE_LOW;
        end
      endcase
    end
  end

  always_comb begin
    pop = 2'b00;
    if (grant_vld) pop = (grant_lane == LANE_HIGH) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // last_grant starts on the high lane so lane 0 wins the first tie.
      last_grant     <= LANE_HIGH;
      bus.o_en       <= 1'b0;
      bus.o_cmd      <= '0;
      bus.o_valid    <= 2'b00;
      bus.o_data_bus <= '0;
    end else if (grant_vld) begin
      last_grant <= grant_lane;
      bus.o_en   <= 1'b1;
      if (grant_lane == LANE_HIGH) begin
        bus.o_cmd      <= COMMAND_WIDTH'(CMD_HIGH);
        bus.o_valid    <= 2'b10;
        bus.o_data_bus <= {head_high, {DATA_WIDTH{1'b0}}};
      end else begin
        bus.o_cmd      <= COMMAND_WIDTH'(CMD_LOW);
        bus.o_valid    <= 2'b01;
        bus.o_data_bus <= {{DATA_WIDTH{1'b0}}, head_low};
      end
    end else begin
      bus.o_en       <= 1'b0;
      bus.o_cmd      <= '0;
      bus.o_valid    <= 2'b00;
      bus.o_data_bus <= '0;
    end
  end

endmodule

// File: tb/tb_mux_2x1_rr_feeder_seq.sv
// Bench for mux_2x1_rr_feeder_seq: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_mux_2x1_rr_feeder_seq;
  import mux_2x1_rr_feeder_seq_pkg::*;

  localparam int DW    = 32;
  localparam int BW    = 2 * DW;
  localparam int DEPTH = FIFO_DEPTH_DEFAULT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_2x1_rr_feeder_seq_if #(.DATA_WIDTH(DW), .COMMAND_WIDTH(1)) bus ();
  logic dbg_last_grant;

  mux_2x1_rr_feeder_seq #(
    .DATA_WIDTH    (DW),
    .COMMAND_WIDTH (1),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_last_grant (dbg_last_grant)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] lane_q0[$];
  logic [DW-1:0] lane_q1[$];
  logic          m_last;
  logic          e_en;
  logic          e_cmd;
  logic [1:0]    e_valid;
  logic [BW-1:0] e_data;
  logic [1:0]    e_ready;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural view: two queues, pick one word per edge by the
  // round-robin rule, then accept pushes against the pre-edge occupancy.
  task automatic model_edge();
    logic r0, r1, n0, n1, g;
    logic [DW-1:0] w;
    if (!rst_n) begin
      lane_q0.delete();
      lane_q1.delete();
      m_last  = 1'b1;
      e_en    = 1'b0;
      e_cmd   = 1'b0;
      e_valid = 2'b00;
      e_data  = '0;
    end else begin
      r0 = (lane_q0.size() < DEPTH);
      r1 = (lane_q1.size() < DEPTH);
      n0 = (lane_q0.size() > 0);
      n1 = (lane_q1.size() > 0);
      if (!bus.i_stall && (n0 || n1)) begin
        g = (n0 && n1) ? ~m_last : n1;
        if (g) w = lane_q1.pop_front();
        else   w = lane_q0.pop_front();
        e_en    = 1'b1;
        e_cmd   = g;
        e_valid = g ? 2'b10 : 2'b01;
        e_data  = g ? {w, {DW{1'b0}}} : {{DW{1'b0}}, w};
        m_last  = g;
      end else begin
        e_en    = 1'b0;
        e_cmd   = 1'b0;
        e_valid = 2'b00;
        e_data  = '0;
      end
      if (bus.i_valid[0] && r0) lane_q0.push_back(bus.i_data_bus[DW-1:0]);
      if (bus.i_valid[1] && r1) lane_q1.push_back(bus.i_data_bus[BW-1:DW]);
    end
    e_ready = {(lane_q1.size() < DEPTH), (lane_q0.size() < DEPTH)};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("o_en",       bus.o_en,       e_en);
    check("o_cmd",      bus.o_cmd,      e_cmd);
    check("o_valid",    bus.o_valid,    e_valid);
    check("o_data_bus", bus.o_data_bus, e_data);
    check("o_ready",    bus.o_ready,    e_ready);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] v, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic st);
    bus.i_valid    = v;
    bus.i_data_bus = {d1, d0};
    bus.i_stall    = st;
    step();
  endtask

  function automatic logic [BW-1:0] on_lane(input logic lane, input logic [DW-1:0] w);
    return lane ? {w, {DW{1'b0}}} : {{DW{1'b0}}, w};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] w;
    logic          c;
    bus.i_valid    = 2'b00;
    bus.i_data_bus = '0;
    bus.i_stall    = 1'b0;

    // Reset held for two edges with both lanes offering data.
    rst_n = 1'b0;
    drive(2'b11, 32'h1111, 32'h2222, 1'b0);
    drive(2'b11, 32'h1111, 32'h2222, 1'b0);
    check("rst_ready", bus.o_ready, 2'b11);
    check("rst_en",    bus.o_en,    1'b0);
    check("rst_data",  bus.o_data_bus, '0);
    rst_n = 1'b1;
    drive(2'b00, '0, '0, 1'b0);
    check("rst_nothing_pushed", bus.o_en, 1'b0);

    // Round-robin from reset: lane 0 wins the first tie.
    drive(2'b11, 32'h10, 32'h20, 1'b1);
    drive(2'b11, 32'h11, 32'h21, 1'b1);
    exp_q = '{32'h10, 32'h20, 32'h11, 32'h21};
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, '0, '0, 1'b0);
      c = (i % 2 == 1);
      w = exp_q.pop_front();
      check("rr_data", bus.o_data_bus, on_lane(c, w));
      check("rr_cmd",  bus.o_cmd, c);
    end
    drive(2'b00, '0, '0, 1'b0);
    check("rr_idle", bus.o_en, 1'b0);

    // Single-lane latency: push at E0, visible after E1, idle after E2.
    drive(2'b01, 32'h0000_00A1, '0, 1'b0);
    check("single_not_yet", bus.o_en, 1'b0);
    drive(2'b00, '0, '0, 1'b0);
    check("single_en",    bus.o_en, 1'b1);
    check("single_cmd",   bus.o_cmd, 1'b0);
    check("single_valid", bus.o_valid, 2'b01);
    check("single_data",  bus.o_data_bus, {32'h0, 32'hA1});
    drive(2'b00, '0, '0, 1'b0);
    check("single_idle", bus.o_en, 1'b0);

    // Full lane 1 under stall; fifth offer must be refused.
    for (int i = 0; i < 4; i++) drive(2'b10, '0, 32'h30 + i, 1'b1);
    check("full_ready", bus.o_ready[1], 1'b0);
    drive(2'b10, '0, 32'h55, 1'b1);
    check("full_refuse", bus.o_ready[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, '0, '0, 1'b0);
      check("full_data", bus.o_data_bus, on_lane(1'b1, 32'h30 + i));
      if (i == 0) check("full_ready_back", bus.o_ready[1], 1'b1);
    end
    drive(2'b00, '0, '0, 1'b0);
    check("full_no_extra", bus.o_en, 1'b0);

    // Stall in the middle of a backlogged burst (last grant is lane 1).
    for (int i = 0; i < 3; i++) drive(2'b11, 32'h40 + i, 32'h50 + i, 1'b1);
    drive(2'b00, '0, '0, 1'b0);
    check("burst_first", bus.o_data_bus, on_lane(1'b0, 32'h40));
    drive(2'b00, '0, '0, 1'b0);
    check("burst_second", bus.o_data_bus, on_lane(1'b1, 32'h50));
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, '0, '0, 1'b1);
      check("stall_idle", bus.o_valid, 2'b00);
    end
    drive(2'b00, '0, '0, 1'b0);
    check("stall_resume_cmd",  bus.o_cmd, 1'b0);
    check("stall_resume_data", bus.o_data_bus, on_lane(1'b0, 32'h41));
    for (int i = 0; i < 5; i++) drive(2'b00, '0, '0, 1'b0);

    // Reset mid-operation flushes queued words.
    for (int i = 0; i < 3; i++) drive(2'b11, 32'h60 + i, 32'h70 + i, 1'b1);
    rst_n = 1'b0;
    drive(2'b11, 32'hDEAD, 32'hBEEF, 1'b0);
    check("midrst_en",    bus.o_en, 1'b0);
    check("midrst_ready", bus.o_ready, 2'b11);
    rst_n = 1'b1;
    drive(2'b10, '0, 32'hEE, 1'b0);
    check("midrst_empty", bus.o_en, 1'b0);
    drive(2'b00, '0, '0, 1'b0);
    check("midrst_first", bus.o_data_bus, on_lane(1'b1, 32'hEE));
    drive(2'b00, '0, '0, 1'b0);
    check("midrst_drained", bus.o_en, 1'b0);

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      drive(2'($urandom_range(0, 3)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) drive(2'b00, '0, '0, 1'b0);
    check("final_drained", bus.o_en, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
